// File: rtl/m68k_bus_arbiter.sv
// 68000 bus ownership arbiter: local Pi engine vs. external masters via BR/BG/BGACK.
// Define ARB_TIMEOUT_EN to abandon a grant that never sees BGACK within TIMEOUT_CYC c7m cycles.
module m68k_bus_arbiter #(
    parameter int BR_QUAL     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic PI_CLK,
    input  logic RST_n,
    input  logic c7m_rise,
    input  logic c7m_fall,
    input  logic M68K_BR_n,
    input  logic M68K_BGACK_n,
    input  logic M68K_AS_n,
    input  logic local_req,
    input  logic local_done,
    output logic local_gnt,
    output logic M68K_BG_n,
    output logic bus_drive_en,
    output logic ext_owner,
    output logic arb_timeout
);

    if (BR_QUAL < 1 || BR_QUAL > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 31) begin : g_param_check
        $error("m68k_bus_arbiter: BR_QUAL or TIMEOUT_CYC out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCAL,
        S_GRANT,
        S_EXT,
        S_RELEASE
    } state_t;

    localparam logic [2:0] LP_QUAL = 3'(BR_QUAL);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_br_sync;
    logic [1:0] r_bgack_sync;
    logic [2:0] r_br_cnt;
    logic       r_bg_n;
    logic       r_local_gnt;
    logic       r_drive_en;
    logic       r_ext_owner;
    logic       r_local_first;
    logic       w_br_s;
    logic       w_bgack_s;
    logic       w_br_q;
    logic       w_bg_n;
    logic       w_local_first;

    assign w_br_s    = r_br_sync[1];
    assign w_bgack_s = r_bgack_sync[1];
    assign w_br_q    = (r_br_cnt == LP_QUAL);

`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] LP_TO_LAST = 5'(TIMEOUT_CYC - 1);
    logic [4:0] r_to_cnt;
    logic [4:0] w_to_cnt;
    logic       r_timeout;
    logic       w_to_set;
`endif

    always_comb begin
        w_next        = r_state;
        w_bg_n        = r_bg_n;
        w_local_first = r_local_first;
`ifdef ARB_TIMEOUT_EN
        w_to_cnt      = r_to_cnt;
        w_to_set      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_bg_n = 1'b1;
                // An external request beats a same-cycle local request unless the
                // local side was promised the next slot.
                if (w_br_q && !r_local_first)
                    w_next = S_GRANT;
                else if (local_req && c7m_rise)
                    w_next = S_LOCAL;
            end
            S_LOCAL: begin
                if (local_done) begin
                    w_next        = S_IDLE;
                    w_local_first = 1'b0;
                end
            end
            S_GRANT: begin
                if (c7m_fall) begin
                    if (r_bg_n) begin
                        if (w_br_q) begin
                            w_bg_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
                            w_to_cnt = 5'd0;
`endif
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else if (!w_bgack_s && M68K_AS_n) begin
                        // AS still low means the previous owner's cycle is in flight.
                        w_next = S_EXT;
                        w_bg_n = 1'b1;
                    end else if (!w_br_q) begin
                        w_next = S_IDLE;
                        w_bg_n = 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_to_cnt == LP_TO_LAST) begin
                        w_next        = S_IDLE;
                        w_bg_n        = 1'b1;
                        w_to_set      = 1'b1;
                        w_local_first = 1'b1;
                    end else begin
                        w_to_cnt = r_to_cnt + 5'd1;
                    end
`endif
                end
            end
            S_EXT: begin
                w_bg_n = 1'b1;
                if (c7m_fall && w_bgack_s)
                    w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (c7m_fall) begin
                    w_next = S_IDLE;
                    if (local_req)
                        w_local_first = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
                w_bg_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state       <= S_IDLE;
            r_br_sync     <= 2'b11;
            r_bgack_sync  <= 2'b11;
            r_br_cnt      <= 3'd0;
            r_bg_n        <= 1'b1;
            r_local_gnt   <= 1'b0;
            r_drive_en    <= 1'b1;
            r_ext_owner   <= 1'b0;
            r_local_first <= 1'b0;
        end else begin
            r_br_sync    <= {r_br_sync[0], M68K_BR_n};
            r_bgack_sync <= {r_bgack_sync[0], M68K_BGACK_n};
            if (c7m_fall) begin
                if (w_br_s)
                    r_br_cnt <= 3'd0;
                else if (r_br_cnt != LP_QUAL)
                    r_br_cnt <= r_br_cnt + 3'd1;
            end
            r_state       <= w_next;
            r_bg_n        <= w_bg_n;
            r_local_first <= w_local_first;
            r_local_gnt   <= (w_next == S_LOCAL);
            r_ext_owner   <= (w_next == S_EXT);
            // Stay off the bus for one extra PI_CLK after RELEASE ends.
            r_drive_en    <= !((w_next == S_EXT) || (w_next == S_RELEASE) || (r_state == S_RELEASE));
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_to_cnt  <= 5'd0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt;
            if (w_to_set)
                r_timeout <= 1'b1;
            else if (local_done)
                r_timeout <= 1'b0;
        end
    end

    assign arb_timeout = r_timeout;
`else
    assign arb_timeout = 1'b0;
`endif

    assign local_gnt    = r_local_gnt;
    assign M68K_BG_n    = r_bg_n;
    assign bus_drive_en = r_drive_en;
    assign ext_owner    = r_ext_owner;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Scoreboard bench for m68k_bus_arbiter: expected output-vector changes are queued by the
// stimulus and consumed by a monitor; latency and hold points are checked directly.
module tb_m68k_bus_arbiter;

    localparam int BRQ = 2;

    logic PI_CLK = 1'b0;
    logic RST_n, c7m_rise, c7m_fall, M68K_BR_n, M68K_BGACK_n, M68K_AS_n;
    logic local_req, local_done;
    logic local_gnt, M68K_BG_n, bus_drive_en, ext_owner, arb_timeout;

    int tests = 0;
    int fails = 0;
    int fall_cnt = 0;
    bit mon_en = 1'b0;
    logic [4:0] exp_q[$];

    // vector bits: {BG_n, local_gnt, bus_drive_en, ext_owner, arb_timeout}
    localparam logic [4:0] V_IDLE  = 5'b10100;
    localparam logic [4:0] V_LOCAL = 5'b11100;
    localparam logic [4:0] V_GRANT = 5'b00100;
    localparam logic [4:0] V_EXT   = 5'b10010;
    localparam logic [4:0] V_REL   = 5'b10000;

    m68k_bus_arbiter #(.BR_QUAL(BRQ), .TIMEOUT_CYC(16)) dut (
        .PI_CLK(PI_CLK), .RST_n(RST_n), .c7m_rise(c7m_rise), .c7m_fall(c7m_fall),
        .M68K_BR_n(M68K_BR_n), .M68K_BGACK_n(M68K_BGACK_n), .M68K_AS_n(M68K_AS_n),
        .local_req(local_req), .local_done(local_done), .local_gnt(local_gnt),
        .M68K_BG_n(M68K_BG_n), .bus_drive_en(bus_drive_en), .ext_owner(ext_owner),
        .arb_timeout(arb_timeout)
    );

    always #5 PI_CLK = ~PI_CLK;

    initial begin
        int phase = 0;
        c7m_rise = 1'b0;
        c7m_fall = 1'b0;
        forever begin
            @(posedge PI_CLK);
            #1;
            c7m_rise = (phase == 0);
            c7m_fall = (phase == 4);
            phase = (phase + 1) % 8;
        end
    end

    always @(posedge PI_CLK) if (c7m_fall) fall_cnt <= fall_cnt + 1;

    function automatic logic [4:0] cur_vec();
        return {M68K_BG_n, local_gnt, bus_drive_en, ext_owner, arb_timeout};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_falls(input int n);
        int target = fall_cnt + n;
        int guard = 0;
        while (fall_cnt < target && guard < n * 8 + 16) begin
            @(negedge PI_CLK);
            guard++;
        end
        if (fall_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL wait_falls: c7m strobes stopped at %0t", $time);
        end
    endtask

    task automatic wait_out(input string nm, input int idx, input logic val, input int limit);
        int n = 0;
        logic [4:0] v = cur_vec();
        while (v[idx] !== val && n < limit) begin
            @(negedge PI_CLK);
            n++;
            v = cur_vec();
        end
        tests++;
        if (v[idx] !== val) begin
            fails++;
            $display("FAIL %s: got %b required %b within %0d cycles", nm, v[idx], val, limit);
        end
    endtask

    task automatic pulse_done();
        local_done = 1'b1;
        @(negedge PI_CLK);
        local_done = 1'b0;
    endtask

    // Monitor: every change of the output vector must match the next queued expectation.
    initial begin
        logic [4:0] prev = V_IDLE;
        logic [4:0] cur;
        logic [4:0] e;
        forever begin
            @(negedge PI_CLK);
            cur = cur_vec();
            if (mon_en && cur !== prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL seq_unexpected: got %b with nothing queued at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("seq", 32'(cur), 32'(e));
                end
            end
            prev = cur;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n = 1'b0; M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1; M68K_AS_n = 1'b1;
        local_req = 1'b0; local_done = 1'b0;
        repeat (3) @(negedge PI_CLK);
        RST_n = 1'b1;
        chk("reset_vec", 32'(cur_vec()), 32'(V_IDLE));
        mon_en = 1'b1;

        // Quiet bus for 20 c7m cycles: any output change is flagged by the monitor.
        wait_falls(20);
        chk("idle_vec", 32'(cur_vec()), 32'(V_IDLE));

        // Plain local cycle.
        exp_q.push_back(V_LOCAL); exp_q.push_back(V_IDLE);
        local_req = 1'b1;
        wait_out("local_gnt_rise", 3, 1'b1, 10);
        local_req = 1'b0;
        repeat (3) @(negedge PI_CLK);
        pulse_done();
        chk("local_gnt_fall", 32'(local_gnt), 32'(0));

        // BR arrives during LOCAL and is deferred.
        wait_falls(1);
        exp_q.push_back(V_LOCAL);
        local_req = 1'b1;
        wait_out("local_gnt_rise2", 3, 1'b1, 10);
        local_req = 1'b0;
        M68K_BR_n = 1'b0;
        wait_falls(6);
        chk("br_deferred", 32'(M68K_BG_n), 32'(1));
        exp_q.push_back(V_IDLE); exp_q.push_back(V_GRANT);
        pulse_done();
        wait_out("bg_after_done", 4, 1'b0, (BRQ + 1) * 8);

        // AS low holds off EXT even with BGACK low.
        wait_falls(1);
        M68K_AS_n = 1'b0;
        M68K_BGACK_n = 1'b0;
        wait_falls(2);
        chk("as_hold_drv", 32'(bus_drive_en), 32'(1));
        chk("as_hold_bg", 32'(M68K_BG_n), 32'(0));
        exp_q.push_back(V_EXT);
        M68K_AS_n = 1'b1;
        wait_falls(1);
        chk("ext_drv_off", 32'(bus_drive_en), 32'(0));
        chk("ext_bg_neg", 32'(M68K_BG_n), 32'(1));

        // Local request pending during tenure gets one cycle before the next grant.
        local_req = 1'b1;
        wait_falls(2);
        chk("no_gnt_in_ext", 32'(local_gnt), 32'(0));
        exp_q.push_back(V_REL); exp_q.push_back(V_IDLE); exp_q.push_back(V_LOCAL);
        M68K_BGACK_n = 1'b1;
        wait_falls(1);
        chk("release_owner", 32'(ext_owner), 32'(0));
        wait_falls(1);
        chk("release_tristate", 32'(bus_drive_en), 32'(0));
        wait_out("local_first_gnt", 3, 1'b1, 12);
        chk("local_first_bg", 32'(M68K_BG_n), 32'(1));
        exp_q.push_back(V_IDLE); exp_q.push_back(V_GRANT);
        local_req = 1'b0;
        pulse_done();
        wait_out("regrant_bg", 4, 1'b0, 16);
        exp_q.push_back(V_IDLE);
        M68K_BR_n = 1'b1;
        wait_out("br_drop_bg", 4, 1'b1, 24);

        // BR low for exactly BR_QUAL falls, gone before BGACK.
        exp_q.push_back(V_GRANT); exp_q.push_back(V_IDLE);
        M68K_BR_n = 1'b0;
        wait_falls(BRQ);
        M68K_BR_n = 1'b1;
        wait_falls(1);
        chk("pulse_bg_on", 32'(M68K_BG_n), 32'(0));
        wait_falls(1);
        chk("pulse_bg_off", 32'(M68K_BG_n), 32'(1));
        chk("pulse_no_to", 32'(arb_timeout), 32'(0));

        // Grant with BGACK never arriving.
        exp_q.push_back(V_GRANT);
        M68K_BR_n = 1'b0;
        wait_out("grant_bg", 4, 1'b0, (BRQ + 1) * 8 + 8);
`ifdef ARB_TIMEOUT_EN
        exp_q.push_back(5'b10101);
        wait_falls(15);
        chk("to_not_yet", 32'(M68K_BG_n), 32'(0));
        wait_falls(1);
        chk("to_bg", 32'(M68K_BG_n), 32'(1));
        chk("to_flag", 32'(arb_timeout), 32'(1));
        exp_q.push_back(5'b11101); exp_q.push_back(V_IDLE); exp_q.push_back(V_GRANT);
        local_req = 1'b1;
        wait_out("to_local_gnt", 3, 1'b1, 12);
        local_req = 1'b0;
        pulse_done();
        chk("to_cleared", 32'(arb_timeout), 32'(0));
        wait_out("to_regrant", 4, 1'b0, 16);
`else
        wait_falls(20);
        chk("wait_bg_held", 32'(M68K_BG_n), 32'(0));
        chk("wait_no_to", 32'(arb_timeout), 32'(0));
`endif

        // Reset in the middle of an external tenure.
        exp_q.push_back(V_EXT);
        M68K_BGACK_n = 1'b0;
        wait_falls(1);
        chk("ext_owner_on", 32'(ext_owner), 32'(1));
        exp_q.push_back(V_IDLE);
        @(negedge PI_CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("rst_bg", 32'(M68K_BG_n), 32'(1));
        chk("rst_drv", 32'(bus_drive_en), 32'(1));
        chk("rst_ext", 32'(ext_owner), 32'(0));
        repeat (3) @(negedge PI_CLK);
        M68K_BGACK_n = 1'b1;
        M68K_BR_n = 1'b1;
        repeat (3) @(negedge PI_CLK);
        RST_n = 1'b1;
        wait_falls(4);
        chk("post_rst_vec", 32'(cur_vec()), 32'(V_IDLE));
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m68k_bus_arbiter.md
# m68k_bus_arbiter

Sequences ownership of the 68000 bus between the local Pi transaction engine and external bus masters using the BR/BG/BGACK protocol. It sits beside the transaction state machine in the CPLD top level, clocked from the Pi clock, and consumes the existing c7m edge strobes. It gates the engine's start of cycle (`local_gnt`), drives `M68K_BG_n`, and produces the tri-state enable for FC/AS/UDS/LDS/RW/VMA.

## Interface
- `BR_QUAL`, default 2: consecutive c7m falling-edge samples of BR low required to qualify a request (1..4).
- `TIMEOUT_CYC`, default 16: c7m cycles to wait for BGACK after BG asserted (only with timeout enabled; 2..31).
- `PI_CLK  in  1`: sole clock, rising-edge.
- `RST_n  in  1`: asynchronous active-low reset.
- `c7m_rise  in  1`: one-PI_CLK strobe on a synchronized 68k clock rising edge.
- `c7m_fall  in  1`: one-PI_CLK strobe on a synchronized 68k clock falling edge.
- `M68K_BR_n  in  1`: external bus request, asynchronous.
- `M68K_BGACK_n  in  1`: external bus grant acknowledge, asynchronous.
- `M68K_AS_n  in  1`: bus address strobe as seen on the pin.
- `local_req  in  1`: engine has a pending cycle; held until granted.
- `local_done  in  1`: one-cycle pulse when the engine finishes its cycle (S7).
- `local_gnt  out  1`: engine may start its cycle; level, held until `local_done`.
- `M68K_BG_n  out  1`: bus grant to external master.
- `bus_drive_en  out  1`: 1 = the local side drives the bus control outputs; 0 = tri-state.
- `ext_owner  out  1`: external master currently owns the bus.
- `arb_timeout  out  1`: sticky flag; cleared by `RST_n` or by a `local_done` pulse.

## Operation
- `M68K_BR_n` and `M68K_BGACK_n` each pass through a 2-flop PI_CLK synchronizer (`br_s`, `bgack_s`).
- BR qualification:
  - A shift counter samples `br_s` on every `c7m_fall`.
  - `br_q` = 1 after `BR_QUAL` consecutive low samples; cleared on the first high sample.
- States:
  - **IDLE**: `bus_drive_en`=1, BG high.
    - `br_q` and not `local_first` → GRANT.
    - Else `local_req` on `c7m_rise` → LOCAL.
    - Simultaneous `br_q` and `local_req` with `local_first`=0: the external request wins.
  - **LOCAL**: `local_gnt`=1. A BR arriving here is deferred.
    - `local_done` → IDLE, `local_gnt`=0 in the next cycle, `local_first` cleared.
  - **GRANT**: BG asserted low on the next `c7m_fall` after entry.
    - `bgack_s`=0 and `M68K_AS_n`=1 sampled on `c7m_fall` → EXT.
    - `br_q` drops before BGACK → BG negated on the next `c7m_fall` → IDLE.
  - **EXT**: BG negated on entry, `bus_drive_en`=0, `ext_owner`=1.
    - `bgack_s`=1 sampled on `c7m_fall` → RELEASE.
  - **RELEASE**: stays tri-stated for one more full c7m cycle (next `c7m_fall`), then → IDLE.
    - Sets `local_first`=1 if `local_req`=1, so one pending local cycle is served before the next grant.
- `M68K_AS_n` low in GRANT holds the transition to EXT: the previous owner's cycle must finish first.
- `local_req` asserted in GRANT/EXT/RELEASE stays pending; `local_gnt` is never asserted while `ext_owner`=1.

## Timing
- Reset values:
  - `M68K_BG_n`=1, `local_gnt`=0, `bus_drive_en`=1, `ext_owner`=0, `arb_timeout`=0.
  - State IDLE, `local_first`=0, qualification counter 0.
- Request latency:
  - BR pin low to `br_q`: 2 PI_CLK (sync) + `BR_QUAL` c7m falling edges.
  - `br_q` to BG low: ≤1 further c7m cycle.
- Outputs are registered. `local_gnt` rises 1 PI_CLK after the `c7m_rise` that is accepted in IDLE.
- `bus_drive_en` falls in the same PI_CLK that EXT is entered. It rises 1 PI_CLK after leaving RELEASE.
- RST_n asserted mid-tenure: all outputs go to their reset values immediately. BG is negated and the bus is driven by the local side, even if BGACK is still low.
  - The `M68K_BGACK_n`-based pin gating in the top level still prevents contention.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In GRANT, a 5-bit counter counts `c7m_fall` strobes from BG assertion.
  - At `TIMEOUT_CYC` with no BGACK, BG is negated, `arb_timeout` is set, and the state goes to IDLE with `local_first`=1.
- `ARB_TIMEOUT_EN` not defined:
  - GRANT waits indefinitely while `br_q`=1.
  - The counter is absent and `arb_timeout` is tied to 0.

## Test plan
- Reset, then idle 20 c7m cycles → BG_n=1, `bus_drive_en`=1, `local_gnt`=0 throughout.
- `local_req`=1, no BR → `local_gnt`=1 within 1 c7m cycle. `local_done` pulse → `local_gnt`=0 the next PI_CLK.
- BR low during LOCAL:
  - BG_n stays 1 until `local_done`.
  - BG_n then goes 0 within `BR_QUAL`+1 c7m cycles.
  - BGACK low with AS high → `bus_drive_en`=0 and BG_n=1 at the next `c7m_fall`.
- BGACK high after an EXT tenure while `local_req`=1 and BR still low → one local cycle is granted before BG_n is asserted again.
- BR pulse low for exactly `BR_QUAL` c7m falls, then high before BGACK → BG_n asserts, then returns to 1 on the next `c7m_fall`; `arb_timeout`=0.
- With `ARB_TIMEOUT_EN`, BR held low, BGACK never asserted → BG_n=1 and `arb_timeout`=1 after 16 c7m falls. RST_n low during EXT → BG_n=1 and `bus_drive_en`=1 immediately.
